fwd_scoreboard: RTL and testbench

Generalised operand forwarding and hazard unit for the integer pipeline, replacing the fixed two-source, five-operand forwarder. It serves `NRD` ID-stage read ports. For each port it selects forwarded data from MEM, WB or a long-latency completion bus. It keeps a per-register pending scoreboard for multi-cycle operations (div/mul) and raises a registered-cause stall for load-use, long-latency RAW and WAW hazards.

---
 rtl/fwd_scoreboard_pkg.sv | 27 ++
 rtl/fwd_scoreboard_if.sv | 49 ++++
 rtl/fwd_scoreboard_port_mux.sv | 48 ++++
 rtl/fwd_scoreboard.sv | 96 +++++++++
 tb/tb_fwd_scoreboard.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// cpuDefine: shared types for the integer pipeline forwarding/hazard logic.
//   Gr         - architectural register number
//   DType      - default datapath word
//   StallCause - encoding of the registered stall reason
//   ZERO_REG   - hard-wired zero register
//   reg_hit()  - writer-to-reader register match (r0 never matches)
package cpuDefine;

  localparam int XLEN_DEF = 32;

  typedef logic [4:0]          Gr;
  typedef logic [XLEN_DEF-1:0] DType;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_USE = 2'd1,
    LONG_RAW = 2'd2,
    WAW      = 2'd3
  } StallCause;

  localparam Gr ZERO_REG = 5'd0;

  function automatic logic reg_hit(input logic we, input Gr wr, input Gr rd);
    return we && (wr != ZERO_REG) && (wr == rd);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: ID read ports, pipeline writers, long-latency bus and
// resolved forwarding/stall outputs.
//   master - pipeline side (drives read ports and writers, sees results)
//   slave  - fwd_scoreboard side
interface fwd_scoreboard_if #(
  parameter int NRD  = 3,
  parameter int XLEN = 32
);
  import cpuDefine::*;

  logic [NRD-1:0]           rd_use;
  Gr    [NRD-1:0]           rd_no;
  logic [NRD-1:0][XLEN-1:0] rd_rf;
  logic                     id_wr_en;
  Gr                        id_wr_no;
  logic                     mem_we;
  Gr                        mem_rd;
  logic [XLEN-1:0]          mem_data;
  logic                     mem_is_load;
  logic                     wb_we;
  Gr                        wb_rd;
  logic [XLEN-1:0]          wb_data;
  logic                     lr_issue;
  Gr                        lr_issue_rd;
  logic                     lr_done;
  Gr                        lr_done_rd;
  logic [XLEN-1:0]          lr_done_data;
  logic                     lr_kill;
  logic [NRD-1:0][XLEN-1:0] fwd_data;
  logic                     stall;
  StallCause                stall_cause;

  modport master (
    output rd_use, rd_no, rd_rf, id_wr_en, id_wr_no,
           mem_we, mem_rd, mem_data, mem_is_load,
           wb_we, wb_rd, wb_data,
           lr_issue, lr_issue_rd, lr_done, lr_done_rd, lr_done_data, lr_kill,
    input  fwd_data, stall, stall_cause
  );

  modport slave (
    input  rd_use, rd_no, rd_rf, id_wr_en, id_wr_no,
           mem_we, mem_rd, mem_data, mem_is_load,
           wb_we, wb_rd, wb_data,
           lr_issue, lr_issue_rd, lr_done, lr_done_rd, lr_done_data, lr_kill,
    output fwd_data, stall, stall_cause
  );

endinterface

// File: rtl/fwd_scoreboard_port_mux.sv
// fwd_port_mux: one ID read port. Priority select MEM > WB > long-latency
// completion > register file, plus this port's load-use and long-RAW flags.
//   rd_use/rd_no/rd_rf     - read port request and register-file data
//   mem_*/wb_*/lr_done_*   - candidate forwarding sources
//   rd_pending             - scoreboard bit for rd_no
//   fwd_data               - resolved operand
//   load_use/long_raw      - hazard flags for this port
module fwd_port_mux
  import cpuDefine::*;
#(
  parameter int XLEN = 32
) (
  input  logic            rd_use,
  input  Gr               rd_no,
  input  logic [XLEN-1:0] rd_rf,
  input  logic            mem_we,
  input  Gr               mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_is_load,
  input  logic            wb_we,
  input  Gr               wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lr_done,
  input  Gr               lr_done_rd,
  input  logic [XLEN-1:0] lr_done_data,
  input  logic            rd_pending,
  output logic [XLEN-1:0] fwd_data,
  output logic            load_use,
  output logic            long_raw
);

  always_comb begin
    fwd_data = rd_rf;
    if (rd_no == ZERO_REG)
      fwd_data = '0;
    else if (reg_hit(mem_we && !mem_is_load, mem_rd, rd_no))
      fwd_data = mem_data;
    else if (reg_hit(wb_we, wb_rd, rd_no))
      fwd_data = wb_data;
    else if (reg_hit(lr_done, lr_done_rd, rd_no))
      fwd_data = lr_done_data;
  end

  assign load_use = rd_use && reg_hit(mem_we && mem_is_load, mem_rd, rd_no);
  // A completion returning this register is forwarded, so it does not stall.
  assign long_raw = rd_use && rd_pending && !reg_hit(lr_done, lr_done_rd, rd_no);

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand forwarding and hazard unit for NRD ID read ports.
// Holds the long-latency pending scoreboard, WAW check and stall-cause FSM.
//   clk, reset  - clock, asynchronous active-high reset
//   bus         - fwd_scoreboard_if slave (read ports, writers, results)
//   stall_cycles- saturating count of stalled cycles (only when
//                 FWD_PERF_CNT_EN is defined)
module fwd_scoreboard
  import cpuDefine::*;
#(
  parameter int NRD  = 3,
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic               clk,
  input  logic               reset,
  fwd_scoreboard_if.slave    bus
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  logic [NREG-1:0]          pending;
  logic [NREG-1:0]          pending_nxt;
  logic [NRD-1:0]           load_use_v;
  logic [NRD-1:0]           long_raw_v;
  logic [NRD-1:0][XLEN-1:0] fwd_v;
  logic                     waw;
  logic                     stall;
  StallCause                cause_q;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    fwd_port_mux #(.XLEN(XLEN)) u_port (
      .rd_use      (bus.rd_use[k]),
      .rd_no       (bus.rd_no[k]),
      .rd_rf       (bus.rd_rf[k]),
      .mem_we      (bus.mem_we),
      .mem_rd      (bus.mem_rd),
      .mem_data    (bus.mem_data),
      .mem_is_load (bus.mem_is_load),
      .wb_we       (bus.wb_we),
      .wb_rd       (bus.wb_rd),
      .wb_data     (bus.wb_data),
      .lr_done     (bus.lr_done),
      .lr_done_rd  (bus.lr_done_rd),
      .lr_done_data(bus.lr_done_data),
      .rd_pending  (pending[bus.rd_no[k]]),
      .fwd_data    (fwd_v[k]),
      .load_use    (load_use_v[k]),
      .long_raw    (long_raw_v[k])
    );
  end

  // Ordering gives set-over-clear and kill-over-everything.
  always_comb begin
    pending_nxt = pending;
    if (bus.lr_done)
      pending_nxt[bus.lr_done_rd] = 1'b0;
    if (bus.lr_issue && bus.lr_issue_rd != ZERO_REG)
      pending_nxt[bus.lr_issue_rd] = 1'b1;
    if (bus.lr_kill)
      pending_nxt = '0;
    pending_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign waw   = bus.id_wr_en && pending[bus.id_wr_no]
                 && !reg_hit(bus.lr_done, bus.lr_done_rd, bus.id_wr_no);
  assign stall = (|load_use_v) || (|long_raw_v) || waw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cause_q <= IDLE;
    else if (|load_use_v)   cause_q <= LOAD_USE;
    else if (|long_raw_v)   cause_q <= LONG_RAW;
    else if (waw)           cause_q <= WAW;
    else                    cause_q <= IDLE;
  end

  assign bus.fwd_data    = fwd_v;
  assign bus.stall       = stall;
  assign bus.stall_cause = cause_q;

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Testbench for fwd_scoreboard: forwarding table, hand-written hazard
// sequences and randomized traffic against a set-based reference model.
// Builds with or without FWD_PERF_CNT_EN.
module tb_fwd_scoreboard;
  import cpuDefine::*;

  localparam int NRD  = 3;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.NRD(NRD), .XLEN(XLEN)) bus ();

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  fwd_scoreboard #(.NRD(NRD), .XLEN(XLEN), .NREG(NREG)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: set of registers with an outstanding long-latency op.
  bit          m_pend[int];
  StallCause   m_cause = IDLE;
  logic [31:0] m_cnt   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit done_for(input Gr r);
    return bus.lr_done && bus.lr_done_rd == r;
  endfunction

  function automatic logic [31:0] exp_fwd(input int k);
    Gr r = bus.rd_no[k];
    if (r == 0) return '0;
    if (bus.mem_we && !bus.mem_is_load && bus.mem_rd == r) return bus.mem_data;
    if (bus.wb_we && bus.wb_rd == r) return bus.wb_data;
    if (bus.lr_done && bus.lr_done_rd == r) return bus.lr_done_data;
    return bus.rd_rf[k];
  endfunction

  function automatic bit in_flight(input Gr r);
    return m_pend.exists(int'(r));
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_cause = IDLE;
    m_cnt   = '0;
  endtask

  // Checks all outputs against the model shortly after inputs change, then
  // advances the model to what the next clock edge should commit.
  task automatic step();
    bit lu, raw, ww, stl;
    #1;
    lu = 0; raw = 0;
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("fwd%0d", k), bus.fwd_data[k], exp_fwd(k));
      if (bus.rd_use[k] && bus.mem_we && bus.mem_is_load &&
          bus.mem_rd != 0 && bus.mem_rd == bus.rd_no[k]) lu = 1;
      if (bus.rd_use[k] && in_flight(bus.rd_no[k]) && !done_for(bus.rd_no[k])) raw = 1;
    end
    ww  = bus.id_wr_en && in_flight(bus.id_wr_no) && !done_for(bus.id_wr_no);
    stl = lu | raw | ww;
    check("stall", 32'(bus.stall), 32'(stl));
    check("cause", 32'(bus.stall_cause), 32'(m_cause));
`ifdef FWD_PERF_CNT_EN
    check("stall_cycles", stall_cycles, m_cnt);
`endif
    m_cause = lu ? LOAD_USE : raw ? LONG_RAW : ww ? WAW : IDLE;
    if (bus.lr_kill) m_pend.delete();
    else begin
      if (bus.lr_done) m_pend.delete(int'(bus.lr_done_rd));
      if (bus.lr_issue && bus.lr_issue_rd != 0) m_pend[int'(bus.lr_issue_rd)] = 1'b1;
    end
    if (stl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic drive_idle();
    bus.rd_use = '0;
    bus.rd_no  = '0;
    for (int k = 0; k < NRD; k++) bus.rd_rf[k] = $urandom;
    bus.id_wr_en = 0; bus.id_wr_no = '0;
    bus.mem_we = 0; bus.mem_rd = '0; bus.mem_data = '0; bus.mem_is_load = 0;
    bus.wb_we = 0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.lr_issue = 0; bus.lr_issue_rd = '0;
    bus.lr_done = 0; bus.lr_done_rd = '0; bus.lr_done_data = '0;
    bus.lr_kill = 0;
  endtask

  typedef struct {
    logic        use0;  Gr rd0;    logic [31:0] rf0;
    logic        mwe;   Gr mrd;    logic [31:0] mdat; logic mld;
    logic        wwe;   Gr wrd;    logic [31:0] wdat;
    logic        dn;    Gr drd;    logic [31:0] ddat;
    logic [31:0] exp_fwd; logic exp_stall;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'hAA,   1'b1, 5'd5, 32'h11, 1'b0, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'h0,  32'h11,   1'b0};
    tbl[1] = '{1'b0, 5'd5, 32'hAA,   1'b1, 5'd5, 32'h11, 1'b1, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'h0,  32'h22,   1'b0};
    tbl[2] = '{1'b1, 5'd6, 32'h99,   1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd6, 32'h22, 1'b1, 5'd6, 32'h55, 32'h22,   1'b0};
    tbl[3] = '{1'b1, 5'd6, 32'h99,   1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h55, 32'h55,   1'b0};
    tbl[4] = '{1'b1, 5'd8, 32'h1234, 1'b1, 5'd9, 32'h1,  1'b0, 1'b1, 5'd10,32'h2,  1'b1, 5'd11,32'h3,  32'h1234, 1'b0};
    tbl[5] = '{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF,
               1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[6] = '{1'b1, 5'd5, 32'hAA,   1'b1, 5'd4, 32'h11, 1'b0, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'h0,  32'h22,   1'b0};
    tbl[7] = '{1'b1, 5'd7, 32'hAA,   1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 5'd7, 32'h33, 1'b0, 5'd0, 32'h0,  32'h33,   1'b1};

    // Reset state with idle inputs.
    drive_idle();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_cause", 32'(bus.stall_cause), 32'(IDLE));
    check("rst_fwd1", bus.fwd_data[1], 32'(0));  // rd_no=0 on every port
`ifdef FWD_PERF_CNT_EN
    check("rst_cnt", stall_cycles, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;
    @(negedge clk); drive_idle(); bus.rd_no[2] = 5'd12; step();
    check("rst_fwd_rf", bus.fwd_data[2], bus.rd_rf[2]);

    // Forwarding table on port 0.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_idle();
      bus.rd_use[0] = tbl[i].use0; bus.rd_no[0] = tbl[i].rd0; bus.rd_rf[0] = tbl[i].rf0;
      bus.mem_we = tbl[i].mwe; bus.mem_rd = tbl[i].mrd; bus.mem_data = tbl[i].mdat;
      bus.mem_is_load = tbl[i].mld;
      bus.wb_we = tbl[i].wwe; bus.wb_rd = tbl[i].wrd; bus.wb_data = tbl[i].wdat;
      bus.lr_done = tbl[i].dn; bus.lr_done_rd = tbl[i].drd; bus.lr_done_data = tbl[i].ddat;
      step();
      check($sformatf("tbl%0d_fwd", i), bus.fwd_data[0], tbl[i].exp_fwd);
      check($sformatf("tbl%0d_stall", i), 32'(bus.stall), 32'(tbl[i].exp_stall));
    end

    // Load-use: one stall cycle, then WB supplies the value.
    @(negedge clk); drive_idle();
    bus.mem_we = 1; bus.mem_is_load = 1; bus.mem_rd = 5'd7;
    bus.rd_use[1] = 1; bus.rd_no[1] = 5'd7;
    step();
    check("lu_stall", 32'(bus.stall), 32'd1);
    @(negedge clk); drive_idle();
    bus.wb_we = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'h33;
    bus.rd_use[1] = 1; bus.rd_no[1] = 5'd7;
    step();
    check("lu_fwd", bus.fwd_data[1], 32'h33);
    check("lu_release", 32'(bus.stall), 32'd0);
    check("lu_cause", 32'(bus.stall_cause), 32'(LOAD_USE));

    // Long RAW on r9: stall until the done cycle.
    @(negedge clk); drive_idle(); bus.lr_issue = 1; bus.lr_issue_rd = 5'd9; step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive_idle(); bus.rd_use[0] = 1; bus.rd_no[0] = 5'd9; step();
      check("raw_stall", 32'(bus.stall), 32'd1);
    end
    check("raw_cause", 32'(bus.stall_cause), 32'(LONG_RAW));
    @(negedge clk); drive_idle(); bus.rd_use[0] = 1; bus.rd_no[0] = 5'd9;
    bus.lr_done = 1; bus.lr_done_rd = 5'd9; bus.lr_done_data = 32'h44; step();
    check("raw_done_fwd", bus.fwd_data[0], 32'h44);
    check("raw_done_stall", 32'(bus.stall), 32'd0);
    @(negedge clk); drive_idle(); bus.rd_use[0] = 1; bus.rd_no[0] = 5'd9; step();
    check("raw_cleared", 32'(bus.stall), 32'd0);

    // Same-cycle issue/done: set wins. Kill clears; kill beats issue.
    @(negedge clk); drive_idle();
    bus.lr_issue = 1; bus.lr_issue_rd = 5'd3; bus.lr_done = 1; bus.lr_done_rd = 5'd3; step();
    @(negedge clk); drive_idle(); bus.rd_use[2] = 1; bus.rd_no[2] = 5'd3; step();
    check("set_wins", 32'(bus.stall), 32'd1);
    @(negedge clk); drive_idle(); bus.lr_kill = 1;
    bus.lr_issue = 1; bus.lr_issue_rd = 5'd10; step();
    @(negedge clk); drive_idle(); bus.rd_use[2] = 1; bus.rd_no[2] = 5'd3;
    bus.rd_use[1] = 1; bus.rd_no[1] = 5'd10; step();
    check("kill_clears", 32'(bus.stall), 32'd0);

    // WAW on r12, with done exemption.
    @(negedge clk); drive_idle(); bus.lr_issue = 1; bus.lr_issue_rd = 5'd12; step();
    @(negedge clk); drive_idle(); bus.id_wr_en = 1; bus.id_wr_no = 5'd12; step();
    check("waw_stall", 32'(bus.stall), 32'd1);
    @(negedge clk); drive_idle(); bus.id_wr_en = 1; bus.id_wr_no = 5'd12;
    bus.lr_done = 1; bus.lr_done_rd = 5'd12; step();
    check("waw_done", 32'(bus.stall), 32'd0);
    check("waw_cause", 32'(bus.stall_cause), 32'(WAW));

    // Randomized traffic on a small register window to force collisions.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < NRD; k++) begin
        bus.rd_use[k] = 1'($urandom);
        bus.rd_no[k]  = Gr'($urandom_range(0, 7));
        bus.rd_rf[k]  = $urandom;
      end
      bus.id_wr_en = 1'($urandom); bus.id_wr_no = Gr'($urandom_range(0, 7));
      bus.mem_we = 1'($urandom); bus.mem_rd = Gr'($urandom_range(0, 7));
      bus.mem_data = $urandom; bus.mem_is_load = ($urandom_range(0, 2) == 0);
      bus.wb_we = 1'($urandom); bus.wb_rd = Gr'($urandom_range(0, 7)); bus.wb_data = $urandom;
      bus.lr_issue = ($urandom_range(0, 4) == 0); bus.lr_issue_rd = Gr'($urandom_range(0, 7));
      bus.lr_done = ($urandom_range(0, 3) == 0); bus.lr_done_rd = Gr'($urandom_range(0, 7));
      bus.lr_done_data = $urandom;
      bus.lr_kill = ($urandom_range(0, 49) == 0);
      step();
    end

    // Fresh reset, five stall cycles, then reset mid-stall.
    @(negedge clk); drive_idle(); reset = 1'b1; model_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); drive_idle(); bus.lr_issue = 1; bus.lr_issue_rd = 5'd20; step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); drive_idle(); bus.rd_use[0] = 1; bus.rd_no[0] = 5'd20; step();
    end
    @(negedge clk); drive_idle(); bus.rd_use[0] = 1; bus.rd_no[0] = 5'd20; step();
    check("pre_rst_stall", 32'(bus.stall), 32'd1);
`ifdef FWD_PERF_CNT_EN
    check("cnt_five", stall_cycles, 32'd5);
`endif
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("midrst_stall", 32'(bus.stall), 32'd0);
    check("midrst_cause", 32'(bus.stall_cause), 32'(IDLE));
`ifdef FWD_PERF_CNT_EN
    check("midrst_cnt", stall_cycles, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;
    // Late completion for a register cleared by reset.
    @(negedge clk); drive_idle(); bus.lr_done = 1; bus.lr_done_rd = 5'd20;
    bus.lr_done_data = 32'h55; bus.rd_use[0] = 1; bus.rd_no[0] = 5'd20; step();
    @(negedge clk); drive_idle(); bus.rd_use[0] = 1; bus.rd_no[0] = 5'd20; step();
    check("late_done", 32'(bus.stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
